// File: rtl/reaction_timer_if.sv
// Bundled handshake and display signals between the push-button/timebase logic
// and reaction_timer.
interface reaction_timer_if #(
  parameter int unsigned NDIG = 2
);
  logic                  Tick;
  logic                  Start;
  logic                  Pushn;
  logic                  Show;
  logic                  LEDn;
  logic [4*NDIG-1:0]     Count;
  logic [7*NDIG-1:0]     Digits;
  logic                  FalseStart;
  logic                  Overflow;
  logic                  Busy;

  modport master (
    output Tick, Start, Pushn, Show,
    input  LEDn, Count, Digits, FalseStart, Overflow, Busy
  );

  modport slave (
    input  Tick, Start, Pushn, Show,
    output LEDn, Count, Digits, FalseStart, Overflow, Busy
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time tester: random stimulus delay, BCD timing, false-start and overflow flags.
// Optional best-time register enabled by defining REACTION_BEST_EN.
module seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  // Active-high segments, bit order {g,f,e,d,c,b,a}; non-BCD codes blank.
  always_comb begin
    seg = '0;
    unique case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = '0;
    endcase
  end
endmodule

module reaction_timer #(
  parameter int unsigned NDIG      = 2,
  parameter int unsigned DELAY_MIN = 100,
  parameter int unsigned LFSR_W    = 8
) (
  input  logic            Clock,
  input  logic            Resetn,
  reaction_timer_if.slave bus
);
  localparam int unsigned DW = $clog2(DELAY_MIN + (1 << LFSR_W));
  localparam logic [4*NDIG-1:0] ALL9 = {NDIG{4'h9}};

  function automatic logic [15:0] tap_mask(input int unsigned w);
    case (w)
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0E08;
      13:      tap_mask = 16'h1C80;
      14:      tap_mask = 16'h3802;
      15:      tap_mask = 16'h6000;
      default: tap_mask = 16'hB400;
    endcase
  endfunction

  localparam logic [15:0]       TAPS16 = tap_mask(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS   = TAPS16[LFSR_W-1:0];

  function automatic logic [4*NDIG-1:0] bcd_inc(input logic [4*NDIG-1:0] v);
    logic       carry;
    logic [3:0] d;
    bcd_inc = v;
    carry   = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT, ARMED, DONE} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q;
  logic [DW-1:0]     dly_q, dly_d;
  logic [4*NDIG-1:0] count_q, count_d;
  logic              led_q, led_d;
  logic              fs_q, fs_d;
  logic              ov_q, ov_d;
  logic [4*NDIG-1:0] disp;
  logic [7*NDIG-1:0] digits;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lfsr_q <= LFSR_W'(1);
    end else begin
      lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      dly_q   <= '0;
      count_q <= '0;
      led_q   <= 1'b1;
      fs_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      count_q <= count_d;
      led_q   <= led_d;
      fs_q    <= fs_d;
      ov_q    <= ov_d;
    end
  end

  // A press always takes priority over a Tick arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    count_d = count_q;
    led_d   = led_q;
    fs_d    = fs_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_d = WAIT;
          dly_d   = DW'(DELAY_MIN) + DW'(lfsr_q);
          count_d = '0;
          fs_d    = 1'b0;
          ov_d    = 1'b0;
        end
      end
      WAIT: begin
        if (!bus.Pushn) begin
          state_d = DONE;
          fs_d    = 1'b1;
          count_d = '0;
          led_d   = 1'b1;
        end else if (bus.Tick) begin
          dly_d = dly_q - DW'(1);
          if (dly_q <= DW'(1)) begin
            state_d = ARMED;
            led_d   = 1'b0;
          end
        end
      end
      ARMED: begin
        if (!bus.Pushn) begin
          state_d = DONE;
          led_d   = 1'b1;
        end else if (bus.Tick) begin
          if (count_q == ALL9) begin
            state_d = DONE;
            ov_d    = 1'b1;
            led_d   = 1'b1;
          end else begin
            count_d = bcd_inc(count_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REACTION_BEST_EN
  logic [4*NDIG-1:0] best_q;
  logic              done_q;

  // done_q marks the first DONE cycle so Best is compared once per run.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      best_q <= ALL9;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (state_q == DONE && !done_q && !fs_q && !ov_q && count_q < best_q)
        best_q <= count_q;
    end
  end

  assign disp = bus.Show ? best_q : count_q;
`else
  logic unused_show;
  assign unused_show = bus.Show;
  assign disp        = count_q;
`endif

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    seg7 u_seg7 (
      .bcd (disp[4*g +: 4]),
      .seg (digits[7*g +: 7])
    );
  end

  assign bus.LEDn       = led_q;
  assign bus.Count      = count_q;
  assign bus.Digits     = digits;
  assign bus.FalseStart = fs_q;
  assign bus.Overflow   = ov_q;
  assign bus.Busy       = (state_q == WAIT) || (state_q == ARMED);
endmodule
